life_point_bank: RTL and testbench
==================================

Name: life_point_bank

Overview:
Parametrised multi-player successor to the single-player life-point register. It holds one life-point counter per player, plus a per-player state machine with a post-hit invulnerability window and a timed respawn delay. It also keeps a saturating death counter per player. It sits between the hit-detection/damage logic and the score/display logic; all inputs are level signals that are edge-detected internally.

Parameters:
NUM_PLAYERS, 2, number of independent player channels (1..8)
LP_WIDTH, 10, width of each life-point and damage value
MAX_LP, 10, life points loaded on regen/respawn (must be < 2**LP_WIDTH)
RESET_LP, 0, life points after reset
INVULN_CYCLES, 25000000, clock cycles of invulnerability after a non-lethal hit (0 = none)
RESPAWN_CYCLES, 50000000, clock cycles between regen request while dead and becoming alive (0 = immediate)
DEATH_CNT_WIDTH, 8, width of each death counter

Ports:
clk  in  1  50 MHz system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
isDamaged  in  NUM_PLAYERS  per-player hit level; rising edge = one hit
damagedValue  in  NUM_PLAYERS*LP_WIDTH  per-player damage; player i at [i*LP_WIDTH +: LP_WIDTH]
isRegen  in  NUM_PLAYERS  per-player regen level; rising edge = one request
lifePoint  out  NUM_PLAYERS*LP_WIDTH  per-player remaining life points, same packing
isDead  out  NUM_PLAYERS  high while player state is DEAD or RESPAWN
isInvuln  out  NUM_PLAYERS  high while player state is INVULN
deathCount  out  NUM_PLAYERS*DEATH_CNT_WIDTH  per-player death counter, saturating

Behaviour:
- Reset (async): lifePoint=RESET_LP, deathCount=0, edge-detect history=0, timers=0, isInvuln=0. State is DEAD if RESET_LP==0, else ALIVE.
- Edge detect: each input is registered once. pulse = registered & ~previous. An input rising before edge k is seen at edge k, and state/outputs update at edge k+1 (1-cycle latency). An input held high through reset release yields one pulse.
- damagedValue is sampled in the same cycle the pulse is acted on.
- Per-player FSM states: DEAD, RESPAWN, ALIVE, INVULN.
- ALIVE, damage pulse, damagedValue==0: ignored.
- ALIVE, damage pulse, lifePoint<=damagedValue: lifePoint=0, go DEAD, deathCount+1 (holds at all-ones).
- ALIVE, damage pulse, otherwise: lifePoint-=damagedValue. Go INVULN for exactly INVULN_CYCLES cycles, or stay ALIVE if INVULN_CYCLES==0.
- INVULN: damage pulses are discarded, not queued. Returns to ALIVE after INVULN_CYCLES. A damage pulse acted on in the first ALIVE cycle is accepted.
- ALIVE/INVULN, regen pulse: lifePoint=MAX_LP, state and timer unchanged.
- DEAD, regen pulse: go RESPAWN, lifePoint stays 0. After RESPAWN_CYCLES go ALIVE with lifePoint=MAX_LP, no invulnerability. If RESPAWN_CYCLES==0, go ALIVE directly with MAX_LP.
- RESPAWN: damage and regen pulses ignored.
- DEAD: damage pulses ignored.
- Same-cycle damage and regen: regen wins, damage discarded.
- Players are fully independent; simultaneous events on different players are all processed in the same cycle.
- Timer width is $clog2 of max(INVULN_CYCLES, RESPAWN_CYCLES)+1. A single timer per player is shared between INVULN and RESPAWN.

Optional Feature:
LIFE_POINT_HEAL_EN
- Defined: adds ports isHealed (in, NUM_PLAYERS) and healValue (in, NUM_PLAYERS*LP_WIDTH), edge-detected the same way as the other inputs.
- Heal pulse in ALIVE/INVULN: lifePoint=min(lifePoint+healValue, MAX_LP), computed one bit wider so it cannot overflow. Ignored in DEAD/RESPAWN.
- Same-cycle priority: regen > damage > heal. Heal is discarded if regen or damage acts.
- Undefined: the ports are absent and behaviour is as above.

Test Plan:
(NUM_PLAYERS=2, MAX_LP=10, RESET_LP=0, INVULN_CYCLES=4, RESPAWN_CYCLES=3)
- Reset, then rising isRegen[0] -> isDead[0]=1 for 3 cycles (RESPAWN), then lifePoint[0]=10, isDead[0]=0; player 1 still 0/dead.
- P0 ALIVE at 10, hit 3 -> lifePoint 7 one cycle after the edge, isInvuln=1 for 4 cycles. Hit 2 during the window -> ignored (7). Hit 2 after the window -> 5.
- P0 at 5, hit 5 -> lifePoint 0, isDead=1, deathCount[0]=1. Hit 1023 from 10 -> 0, no underflow, deathCount=2.
- P0 at 7, damage 3 and regen rising the same cycle -> lifePoint 10, isInvuln stays 0.
- P0 hit 4 and P1 regen on the same cycle, both alive at 10 -> P0=6 with invuln, P1=10. Assert reset mid-INVULN -> all outputs return to reset values immediately, without waiting for a clock edge.
- With LIFE_POINT_HEAL_EN: P0 at 6, heal 7 -> 10 (saturated). Heal and hit 2 the same cycle -> hit applied, heal dropped.

Source files
------------

// File: rtl/life_point_bank_if.sv
// -----------------------------------------------------------------------------
// life_point_bank_if
// Bundles the per-player event inputs and status outputs of life_point_bank.
// All vectors are packed per player: player i occupies [i*W +: W].
//   master : driven by hit-detection / damage logic (events in, status back)
//   slave  : the life_point_bank itself
// Optional macro LIFE_POINT_HEAL_EN adds isHealed / healValue.
// -----------------------------------------------------------------------------
interface life_point_bank_if #(
    parameter int NUM_PLAYERS     = 2,
    parameter int LP_WIDTH        = 10,
    parameter int DEATH_CNT_WIDTH = 8
);
    logic [NUM_PLAYERS-1:0]                 isDamaged;
    logic [NUM_PLAYERS*LP_WIDTH-1:0]        damagedValue;
    logic [NUM_PLAYERS-1:0]                 isRegen;
`ifdef LIFE_POINT_HEAL_EN
    logic [NUM_PLAYERS-1:0]                 isHealed;
    logic [NUM_PLAYERS*LP_WIDTH-1:0]        healValue;
`endif
    logic [NUM_PLAYERS*LP_WIDTH-1:0]        lifePoint;
    logic [NUM_PLAYERS-1:0]                 isDead;
    logic [NUM_PLAYERS-1:0]                 isInvuln;
    logic [NUM_PLAYERS*DEATH_CNT_WIDTH-1:0] deathCount;

    modport master (
`ifdef LIFE_POINT_HEAL_EN
        output isHealed, healValue,
`endif
        output isDamaged, damagedValue, isRegen,
        input  lifePoint, isDead, isInvuln, deathCount
    );

    modport slave (
`ifdef LIFE_POINT_HEAL_EN
        input  isHealed, healValue,
`endif
        input  isDamaged, damagedValue, isRegen,
        output lifePoint, isDead, isInvuln, deathCount
    );
endinterface

// File: rtl/life_point_bank.sv
// -----------------------------------------------------------------------------
// life_point_bank
// Multi-player life-point register. Each player has a life-point counter, a
// DEAD/RESPAWN/ALIVE/INVULN state machine sharing one down-counter for the
// invulnerability window and the respawn delay, and a saturating death counter.
// Event inputs are levels; a rising edge is one event. Events are seen one
// clock after they rise and acted on the clock after that.
//
// Ports:
//   clk   : system clock, all state on the rising edge
//   reset : asynchronous active-high reset
//   bus   : life_point_bank_if.slave
//           in  isDamaged/damagedValue, isRegen (, isHealed/healValue)
//           out lifePoint, isDead, isInvuln, deathCount
//
// Optional macro LIFE_POINT_HEAL_EN: enables heal events,
//   lifePoint = min(lifePoint + healValue, MAX_LP) while ALIVE/INVULN.
//   Priority within one cycle is regen > damage > heal.
// -----------------------------------------------------------------------------
module life_point_bank #(
    parameter int NUM_PLAYERS     = 2,
    parameter int LP_WIDTH        = 10,
    parameter int MAX_LP          = 10,
    parameter int RESET_LP        = 0,
    parameter int INVULN_CYCLES   = 25000000,
    parameter int RESPAWN_CYCLES  = 50000000,
    parameter int DEATH_CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    life_point_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_DEAD    = 2'd0,
        ST_RESPAWN = 2'd1,
        ST_ALIVE   = 2'd2,
        ST_INVULN  = 2'd3
    } state_t;

    // One timer serves both windows, so it is sized for the longer one.
    localparam int MAX_CYC = (INVULN_CYCLES > RESPAWN_CYCLES) ? INVULN_CYCLES : RESPAWN_CYCLES;
    localparam int TW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

    // Timer is loaded with N-1 so that the state lasts exactly N cycles.
    localparam logic [TW-1:0] INV_LOAD = TW'((INVULN_CYCLES  > 0) ? INVULN_CYCLES  - 1 : 0);
    localparam logic [TW-1:0] RSP_LOAD = TW'((RESPAWN_CYCLES > 0) ? RESPAWN_CYCLES - 1 : 0);

    localparam logic [LP_WIDTH-1:0] MAX_LP_V   = LP_WIDTH'(MAX_LP);
    localparam logic [LP_WIDTH-1:0] RESET_LP_V = LP_WIDTH'(RESET_LP);
    localparam state_t              RESET_ST   = (RESET_LP == 0) ? ST_DEAD : ST_ALIVE;

    // ---------------- edge detection ----------------
    logic [NUM_PLAYERS-1:0] dmg_sync_reg,   dmg_prev_reg,   dmg_pulse;
    logic [NUM_PLAYERS-1:0] regen_sync_reg, regen_prev_reg, regen_pulse;
`ifdef LIFE_POINT_HEAL_EN
    logic [NUM_PLAYERS-1:0] heal_sync_reg,  heal_prev_reg,  heal_pulse;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dmg_sync_reg   <= '0;
            dmg_prev_reg   <= '0;
            regen_sync_reg <= '0;
            regen_prev_reg <= '0;
`ifdef LIFE_POINT_HEAL_EN
            heal_sync_reg  <= '0;
            heal_prev_reg  <= '0;
`endif
        end else begin
            dmg_sync_reg   <= bus.isDamaged;
            dmg_prev_reg   <= dmg_sync_reg;
            regen_sync_reg <= bus.isRegen;
            regen_prev_reg <= regen_sync_reg;
`ifdef LIFE_POINT_HEAL_EN
            heal_sync_reg  <= bus.isHealed;
            heal_prev_reg  <= heal_sync_reg;
`endif
        end
    end

    assign dmg_pulse   = dmg_sync_reg   & ~dmg_prev_reg;
    assign regen_pulse = regen_sync_reg & ~regen_prev_reg;
`ifdef LIFE_POINT_HEAL_EN
    assign heal_pulse  = heal_sync_reg  & ~heal_prev_reg;
`endif

    // ---------------- per-player channels ----------------
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
        state_t                     state_reg, state_next;
        logic [LP_WIDTH-1:0]        lp_reg, lp_next;
        logic [TW-1:0]              timer_reg, timer_next;
        logic [DEATH_CNT_WIDTH-1:0] death_reg, death_next;
        logic [LP_WIDTH-1:0]        dmg_val;
        logic                       dmg_act;

        // Damage value is taken live, in the cycle its pulse is acted on.
        assign dmg_val = bus.damagedValue[gi*LP_WIDTH +: LP_WIDTH];

`ifdef LIFE_POINT_HEAL_EN
        logic [LP_WIDTH:0]   heal_sum;
        logic [LP_WIDTH-1:0] heal_lp;
        // One bit wider so large heals cannot wrap before the clamp.
        assign heal_sum = {1'b0, lp_reg} + {1'b0, bus.healValue[gi*LP_WIDTH +: LP_WIDTH]};
        assign heal_lp  = (heal_sum > {1'b0, MAX_LP_V}) ? MAX_LP_V : heal_sum[LP_WIDTH-1:0];
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_reg <= RESET_ST;
                lp_reg    <= RESET_LP_V;
                timer_reg <= '0;
                death_reg <= '0;
            end else begin
                state_reg <= state_next;
                lp_reg    <= lp_next;
                timer_reg <= timer_next;
                death_reg <= death_next;
            end
        end

        always_comb begin
            state_next = state_reg;
            lp_next    = lp_reg;
            timer_next = timer_reg;
            death_next = death_reg;
            // Damage only counts while fully ALIVE and non-zero; zero hits
            // and hits during the window are dropped (and do not block heal).
            dmg_act    = (state_reg == ST_ALIVE) && dmg_pulse[gi] && (dmg_val != '0);

            case (state_reg)
                ST_DEAD: begin
                    if (regen_pulse[gi]) begin
                        if (RESPAWN_CYCLES == 0) begin
                            state_next = ST_ALIVE;
                            lp_next    = MAX_LP_V;
                        end else begin
                            state_next = ST_RESPAWN;
                            timer_next = RSP_LOAD;
                        end
                    end
                end
                ST_RESPAWN: begin
                    if (timer_reg == '0) begin
                        state_next = ST_ALIVE;
                        lp_next    = MAX_LP_V;
                    end else begin
                        timer_next = timer_reg - 1'b1;
                    end
                end
                default: begin // ST_ALIVE, ST_INVULN
                    if (state_reg == ST_INVULN) begin
                        if (timer_reg == '0) begin
                            state_next = ST_ALIVE;
                        end else begin
                            timer_next = timer_reg - 1'b1;
                        end
                    end
                    if (regen_pulse[gi]) begin
                        // Regen refills but leaves state and window untouched.
                        lp_next = MAX_LP_V;
                    end else if (dmg_act) begin
                        if (lp_reg <= dmg_val) begin
                            lp_next    = '0;
                            state_next = ST_DEAD;
                            death_next = (&death_reg) ? death_reg : death_reg + 1'b1;
                        end else begin
                            lp_next = lp_reg - dmg_val;
                            if (INVULN_CYCLES != 0) begin
                                state_next = ST_INVULN;
                                timer_next = INV_LOAD;
                            end
                        end
                    end
`ifdef LIFE_POINT_HEAL_EN
                    else if (heal_pulse[gi]) begin
                        lp_next = heal_lp;
                    end
`endif
                end
            endcase
        end

        assign bus.lifePoint[gi*LP_WIDTH +: LP_WIDTH]               = lp_reg;
        assign bus.deathCount[gi*DEATH_CNT_WIDTH +: DEATH_CNT_WIDTH] = death_reg;
        assign bus.isDead[gi]   = (state_reg == ST_DEAD) || (state_reg == ST_RESPAWN);
        assign bus.isInvuln[gi] = (state_reg == ST_INVULN);
    end

endmodule

// File: tb/tb_life_point_bank.sv
// -----------------------------------------------------------------------------
// tb_life_point_bank
// Directed bench for life_point_bank with NUM_PLAYERS=2, MAX_LP=10,
// RESET_LP=0, INVULN_CYCLES=4, RESPAWN_CYCLES=3. Inputs are driven and
// outputs sampled 1 time unit after each rising clock edge. An event raised
// at point n is acted on at the edge that leads to point n+2.
// Heal vectors are included when LIFE_POINT_HEAL_EN is defined.
// -----------------------------------------------------------------------------
module tb_life_point_bank;
    localparam int NP = 2;
    localparam int LW = 10;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    always #5 clk = ~clk;

    life_point_bank_if #(.NUM_PLAYERS(NP), .LP_WIDTH(LW), .DEATH_CNT_WIDTH(DW)) bus ();

    life_point_bank #(
        .NUM_PLAYERS(NP), .LP_WIDTH(LW), .MAX_LP(10), .RESET_LP(0),
        .INVULN_CYCLES(4), .RESPAWN_CYCLES(3), .DEATH_CNT_WIDTH(DW)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check_vec(input string tag, input int unsigned got, input int unsigned exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int unsigned lp(input int p);
        return int'(bus.lifePoint[p*LW +: LW]);
    endfunction

    function automatic int unsigned dc(input int p);
        return int'(bus.deathCount[p*DW +: DW]);
    endfunction

    task automatic set_dmg(input int p, input int unsigned v);
        bus.damagedValue[p*LW +: LW] = LW'(v);
    endtask

    task automatic clear_inputs();
        bus.isDamaged    = '0;
        bus.isRegen      = '0;
        bus.damagedValue = '0;
`ifdef LIFE_POINT_HEAL_EN
        bus.isHealed     = '0;
        bus.healValue    = '0;
`endif
    endtask

    // Regen player p from DEAD: RESPAWN for 3 cycles, ALIVE at point 5.
    task automatic respawn(input int p);
        bus.isRegen[p] = 1'b1;
        tick(5);
        bus.isRegen[p] = 1'b0;
        tick(1);
    endtask

    initial begin
        clear_inputs();
        tick(2);
        check_vec("rst lp0", lp(0), 0);
        check_vec("rst lp1", lp(1), 0);
        check_vec("rst dead", bus.isDead, 2'b11);
        check_vec("rst invuln", bus.isInvuln, 2'b00);
        check_vec("rst dc0", dc(0), 0);
        rst = 1'b0;
        tick(1);

        // ---- respawn timing ----
        bus.isRegen[0] = 1'b1;
        tick(1);
        check_vec("regen latency dead", bus.isDead, 2'b11);
        tick(1);
        check_vec("respawn lp0", lp(0), 0);
        tick(2);
        check_vec("respawn last dead", bus.isDead, 2'b11);
        tick(1);
        check_vec("respawn lp0 full", lp(0), 10);
        check_vec("respawn alive", bus.isDead, 2'b10);
        check_vec("p1 untouched", lp(1), 0);
        bus.isRegen[0] = 1'b0;
        tick(1);

        // ---- hit 3 then invulnerability window ----
        set_dmg(0, 3);
        bus.isDamaged[0] = 1'b1;
        tick(1);
        check_vec("hit latency lp", lp(0), 10);
        tick(1);
        check_vec("hit3 lp", lp(0), 7);
        check_vec("hit3 invuln", bus.isInvuln, 2'b01);
        bus.isDamaged[0] = 1'b0;
        tick(1);
        set_dmg(0, 2);
        bus.isDamaged[0] = 1'b1;
        tick(2);
        check_vec("hit in window lp", lp(0), 7);
        check_vec("window last cycle", bus.isInvuln, 2'b01);
        bus.isDamaged[0] = 1'b0;
        tick(1);
        check_vec("window over", bus.isInvuln, 2'b00);
        bus.isDamaged[0] = 1'b1;
        tick(2);
        check_vec("hit2 lp", lp(0), 5);
        check_vec("hit2 invuln", bus.isInvuln, 2'b01);
        bus.isDamaged[0] = 1'b0;

        // ---- lethal hit acted on in first ALIVE cycle ----
        tick(3);
        set_dmg(0, 5);
        bus.isDamaged[0] = 1'b1;
        tick(1);
        check_vec("first alive lp", lp(0), 5);
        check_vec("first alive invuln", bus.isInvuln, 2'b00);
        tick(1);
        check_vec("lethal lp", lp(0), 0);
        check_vec("lethal dead", bus.isDead, 2'b11);
        check_vec("lethal dc0", dc(0), 1);
        bus.isDamaged[0] = 1'b0;
        tick(1);

        // ---- overkill, no underflow ----
        respawn(0);
        set_dmg(0, 1023);
        bus.isDamaged[0] = 1'b1;
        tick(2);
        check_vec("overkill lp", lp(0), 0);
        check_vec("overkill dc0", dc(0), 2);
        check_vec("overkill invuln", bus.isInvuln, 2'b00);
        bus.isDamaged[0] = 1'b0;
        tick(1);

        // ---- damage in DEAD ignored ----
        set_dmg(0, 1);
        bus.isDamaged[0] = 1'b1;
        tick(2);
        check_vec("dead hit dc0", dc(0), 2);
        bus.isDamaged[0] = 1'b0;
        tick(1);

        // ---- same-cycle damage and regen: regen wins ----
        respawn(0);
        set_dmg(0, 3);
        bus.isDamaged[0] = 1'b1;
        tick(2);
        check_vec("pre lp7", lp(0), 7);
        bus.isDamaged[0] = 1'b0;
        tick(4);
        bus.isDamaged[0] = 1'b1;
        bus.isRegen[0]   = 1'b1;
        tick(2);
        check_vec("dmg+regen lp", lp(0), 10);
        check_vec("dmg+regen invuln", bus.isInvuln, 2'b00);
        bus.isDamaged[0] = 1'b0;
        bus.isRegen[0]   = 1'b0;
        tick(1);

        // ---- independent players in the same cycle ----
        respawn(1);
        set_dmg(1, 1);
        bus.isDamaged[1] = 1'b1;
        tick(2);
        check_vec("p1 hit1 lp", lp(1), 9);
        bus.isDamaged[1] = 1'b0;
        tick(4);
        set_dmg(0, 4);
        bus.isDamaged[0] = 1'b1;
        bus.isRegen[1]   = 1'b1;
        tick(2);
        check_vec("par p0 lp", lp(0), 6);
        check_vec("par p1 lp", lp(1), 10);
        check_vec("par invuln", bus.isInvuln, 2'b01);
        check_vec("par dead", bus.isDead, 2'b00);

        // ---- async reset mid-window, no clock edge in between ----
        rst = 1'b1;
        #2;
        check_vec("async lp0", lp(0), 0);
        check_vec("async lp1", lp(1), 0);
        check_vec("async dead", bus.isDead, 2'b11);
        check_vec("async invuln", bus.isInvuln, 2'b00);
        check_vec("async dc0", dc(0), 0);
        clear_inputs();
        tick(1);
        rst = 1'b0;
        tick(1);

`ifdef LIFE_POINT_HEAL_EN
        // ---- heal saturates, damage beats heal ----
        respawn(0);
        set_dmg(0, 4);
        bus.isDamaged[0] = 1'b1;
        tick(2);
        bus.isDamaged[0] = 1'b0;
        tick(1);
        bus.healValue[0*LW +: LW] = 10'd7;
        bus.isHealed[0] = 1'b1;
        tick(2);
        check_vec("heal sat lp", lp(0), 10);
        bus.isHealed[0] = 1'b0;
        tick(4);
        set_dmg(0, 2);
        bus.isDamaged[0] = 1'b1;
        bus.isHealed[0]  = 1'b1;
        tick(2);
        check_vec("heal+hit lp", lp(0), 8);
        check_vec("heal+hit invuln", bus.isInvuln, 2'b01);
        clear_inputs();
        tick(1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
